// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - execute-stage multiply/divide unit with private HI/LO registers
// Multi-cycle mult/div launch from IDLE, commit on the last RUN cycle; mthi/mtlo write directly.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_busy, w_busy_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_res_hi, w_res_hi_nxt;
  logic [31:0]   r_res_lo, w_res_lo_nxt;
  logic          r_dz, w_dz_nxt;
  logic [31:0]   r_hi, w_hi_nxt;
  logic [31:0]   r_lo, w_lo_nxt;

  logic        w_accept, w_is_md;
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_divisor, w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_is_md  = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_DIV) | (op == OP_DIVU);
  assign w_accept = (r_state == S_IDLE) & start & ~req & ~r_busy;
  assign stall_md = r_busy | (start & w_is_md & ~req);
  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed division via magnitudes: quotient truncates toward zero, remainder follows A.
  // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
  assign w_a_neg   = (op == OP_DIV) & A[31];
  assign w_b_neg   = (op == OP_DIV) & B[31];
  assign w_a_mag   = w_a_neg ? (32'd0 - A) : A;
  assign w_b_mag   = w_b_neg ? (32'd0 - B) : B;
  assign w_divisor = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag   = w_a_mag / w_divisor;
  assign w_r_mag   = w_a_mag % w_divisor;
  assign w_quot    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = r_busy;
    w_cnt_nxt    = r_cnt;
    w_res_hi_nxt = r_res_hi;
    w_res_lo_nxt = r_res_lo;
    w_dz_nxt     = r_dz;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    if (r_state == S_IDLE) begin
      if (w_accept) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            {w_res_hi_nxt, w_res_lo_nxt} = (op == OP_MULT) ? w_prod_s : w_prod_u;
            w_dz_nxt    = 1'b0;
            w_cnt_nxt   = CW'(MULT_CYCLES);
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_RUN;
          end
          OP_DIV, OP_DIVU: begin
            w_res_hi_nxt = w_rem;
            w_res_lo_nxt = w_quot;
            w_dz_nxt     = (B == 32'd0);
            w_cnt_nxt    = CW'(DIV_CYCLES);
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_RUN;
          end
          OP_MTHI: w_hi_nxt = A;
          OP_MTLO: w_lo_nxt = A;
          default: ;
        endcase
      end
    end else begin
      if (r_cnt == CW'(1)) begin
        // Divide by zero still burns its cycles but leaves HI/LO untouched.
        if (!r_dz) begin
          w_hi_nxt = r_res_hi;
          w_lo_nxt = r_res_lo;
        end
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_res_hi <= w_res_hi_nxt;
      r_res_lo <= w_res_lo_nxt;
      r_dz     <= w_dz_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_mdu_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .req      (req),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    #1 check("stall_on_start", {63'd0, stall_md}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int cyc, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    issue(o, a, b);
    wait_idle(n);
    check({tag, "_cycles"}, 64'(n), 64'(cyc));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    int n;
    logic stall_bad;
    logic hi_bad;

    reset = 1'b1;
    start = 1'b0;
    op    = OP_NONE;
    A     = '0;
    B     = '0;
    req   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall_md}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_md("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_md("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",  OP_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // mthi/mtlo are single-cycle
    start = 1'b1; op = OP_MTHI; A = 32'h11;
    @(negedge clk);
    op = OP_MTLO; A = 32'h22;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    check("mthi_hi", {32'd0, hi}, 64'h11);
    check("mtlo_lo", {32'd0, lo}, 64'h22);
    check("mtx_busy", {63'd0, busy}, 64'd0);

    run_md("divu_by0", OP_DIVU, 32'd1234, 32'd0, 10, 32'h11, 32'h22);

    // mthi held while a mult runs: stalled, then lands the cycle busy falls
    start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk);
    op = OP_MTHI; A = 32'h5;
    stall_bad = 1'b0;
    hi_bad    = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      if (stall_md !== 1'b1) stall_bad = 1'b1;
      if (hi !== 32'h11) hi_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("held_cycles", 64'(n), 64'd5);
    check("held_stall", {63'd0, stall_bad}, 64'd0);
    check("held_hi_untouched", {63'd0, hi_bad}, 64'd0);
    check("held_commit_hi", {32'd0, hi}, 64'd0);
    check("held_commit_lo", {32'd0, lo}, 64'd12);
    check("held_stall_released", {63'd0, stall_md}, 64'd0);
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    check("mthi_after_hi", {32'd0, hi}, 64'h5);
    check("mthi_after_lo", {32'd0, lo}, 64'd12);

    // flushed div start
    start = 1'b1; op = OP_DIV; A = 32'd7; B = 32'd2; req = 1'b1;
    #1 check("flush_stall", {63'd0, stall_md}, 64'd0);
    @(negedge clk);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_hi", {32'd0, hi}, 64'h5);
    check("flush_lo", {32'd0, lo}, 64'd12);
    start = 1'b0; op = OP_NONE; req = 1'b0;

    // reserved op does nothing
    start = 1'b1; op = OP_RSVD; A = 32'hDEAD_BEEF;
    #1 check("rsvd_stall", {63'd0, stall_md}, 64'd0);
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    check("rsvd_busy", {63'd0, busy}, 64'd0);
    check("rsvd_hi", {32'd0, hi}, 64'h5);
    check("rsvd_lo", {32'd0, lo}, 64'd12);

    // req pulse during a running multu does not cancel it
    issue(OP_MULTU, 32'h10, 32'h10);
    start = 1'b1; op = OP_MTHI; A = 32'hBAD; req = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_NONE; req = 1'b0;
    wait_idle(n);
    check("req_run_cycles", 64'(n + 1), 64'd5);
    check("req_run_hi", {32'd0, hi}, 64'd0);
    check("req_run_lo", {32'd0, lo}, 64'h100);

    // asynchronous reset in the middle of a div
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; op = OP_MTLO; A = 32'h9;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    check("post_rst_mtlo_lo", {32'd0, lo}, 64'h9);
    check("post_rst_mtlo_hi", {32'd0, hi}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("post_rst_no_commit_hi", {32'd0, hi}, 64'd0);
    check("post_rst_no_commit_lo", {32'd0, lo}, 64'h9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit. It sits beside the ALU and takes the same forwarded rs/rt operands from the D/E pipeline register.
- It runs mult/multu/div/divu over several cycles into private HI/LO registers and performs mthi/mtlo writes.
- It drives a busy signal to the hazard unit and HI/LO values to the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (>=1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  E-stage instruction is an MDU op this cycle (qualifies op)
- op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 reserved, treated as none
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- req  input  1  exception/interrupt flush from CP0; suppresses acceptance this cycle
- busy  output  1  multi-cycle operation in progress (registered)
- stall_md  output  1  combinational: busy | (start & op in {mult,multu,div,divu} & ~req)
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset:
  - hi=0, lo=0, busy=0, cycle counter=0, internal result latches=0.
  - Reset asserted mid-operation aborts it; HI/LO remain 0.
- States: IDLE, RUN.
- Accept condition, evaluated in IDLE: start=1, req=0, busy=0. The op is applied at that rising edge.
- mult/multu accept:
  - 64-bit product of A,B computed: signed for mult, unsigned for multu.
  - Product held in internal latches; counter loaded with MULT_CYCLES; busy=1 from the next cycle; state goes to RUN.
- div/divu accept:
  - Quotient and remainder computed, signed for div, unsigned for divu.
  - Quotient truncates toward zero; remainder takes the sign of the dividend (A).
  - Counter loaded with DIV_CYCLES; busy=1 from the next cycle.
  - Overflow case: div with A=0x80000000, B=0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (B=0): the operation still occupies DIV_CYCLES; at completion hi/lo are left UNCHANGED.
- RUN:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1: hi<=upper word/remainder, lo<=lower word/quotient, busy<=0, state goes to IDLE.
  - busy is therefore high for exactly N cycles. New hi/lo are visible the cycle busy falls.
- mthi/mtlo accept: single-cycle; hi<=A or lo<=A at that edge; busy stays 0.
- start while busy=1: ignored. Upstream is stalled by stall_md, so the instruction is re-presented later.
- req=1:
  - The current-cycle start is ignored (no HI/LO change, no launch) and stall_md does not assert for the start term.
  - An operation already in RUN is NOT cancelled; it completes and commits.
- Result ordering:
  - A new op accepted in the cycle busy falls is legal.
  - mthi/mtlo accepted that cycle sees the committed value overwritten by A.
- op=none or reserved with start=1: no effect.
- hi/lo are plain register outputs, with no bypass of the in-flight result.

Test Plan:
- After reset, start/op=mult, A=0xFFFFFFFF, B=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu A=7, B=2 -> lo=3, hi=1.
- Edge cases:
  - div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - divu with B=0 after hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo stay 0x11/0x22.
- Busy and stall behaviour:
  - mult accepted, then mthi A=0x5 held while busy -> stall_md=1 throughout, hi untouched until completion.
  - mthi A=0x5 applied after busy falls -> hi=0x5.
- Flush behaviour:
  - start=1, op=div, req=1 -> no launch, busy stays 0, stall_md=0.
  - req pulse during a running mult -> mult still commits on schedule.
- Reset interplay:
  - Assert reset asynchronously (between edges) mid-div -> hi=lo=0 and busy=0 immediately.
  - mtlo A=0x9 right after reset release -> lo=0x9 next edge.
